// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE picks the next owner, GRANT streams that owner's beats.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Modular increment used to walk the requesters in round-robin order.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found when searching ptr+1, ptr+2, ... wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan every offset from the pointer; the first hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'(rr_wrap(32'(ptr), unsigned'(k), unsigned'(N)));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// One requester owns the port at a time for up to MAX_BURST beats; a single
// IDLE cycle separates consecutive grants and is where arbitration happens.
//
// Handshake: a beat from requester i transfers on a rising clk edge where
// req_valid[i] and req_ready[i] are both high. req_ready never depends on
// req_valid; the requester must hold req_data/req_last stable while
// valid & !ready. fifo_wr_en is the fifo's push strobe and is only raised
// when fifo_full is low, so every asserted fifo_wr_en is one stored beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output arb_state_t                    dbg_state,
  output logic [CNT_W-1:0]              dbg_beat_cnt
);

  arb_state_t      state;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic            pick_any;
  logic [ID_W-1:0] pick_idx;

  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;

  logic in_grant;
  logic accept;
  logic burst_end;
  logic release_grant;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Select the current owner's valid, last and data lanes.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // rst masks the grant immediately so a beat presented during reset is
  // neither acknowledged nor written.
  assign in_grant      = (state == GRANT) && !rst;
  assign accept        = in_grant && owner_valid && !fifo_full;
  assign burst_end     = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_grant = (accept && (owner_last || burst_end)) || !owner_valid;

  // Drive the fifo port and the per-requester ready from the owner.
  always_comb begin
    req_ready = '0;
    if (in_grant && !fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == ID_W'(i));
      end
    end
    fifo_wr_en   = accept;
    fifo_wr_data = in_grant ? owner_data : '0;
    grant_valid  = in_grant;
    grant_id     = in_grant ? owner : '0;
    dbg_state    = state;
    dbg_beat_cnt = beat_cnt;
  end

  // Arbitration FSM with owner, round-robin pointer and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            owner    <= pick_idx;
            rr_ptr   <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          // Full fifo stalls the burst in place; only last, burst limit
          // or the owner withdrawing ends a grant.
          if (release_grant) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4) with a
// 16-entry fifo modelled behind the write port.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          grant_valid;
  logic [1:0]    grant_id;
  arb_state_t    dbg_state;
  logic [2:0]    dbg_beat_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_rst = 1'b1;

  // The fifo behind the arbiter stores every pushed beat.
  always @(posedge clk) begin
    if (fifo_wr_en === 1'b1) fifo_q.push_back(fifo_wr_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reads the fifo back completely and compares it with the expected beats.
  task automatic drain_check(input string name);
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    chk({name, ".fifo_count"}, 32'(fifo_q.size()), 32'(exp_q.size()));
    while (fifo_q.size() > 0 && exp_q.size() > 0) begin
      got  = fifo_q.pop_front();
      want = exp_q.pop_front();
      chk({name, ".fifo_data"}, 32'(got), 32'(want));
    end
    fifo_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Drives inputs, checks outputs at the falling edge, then advances past
  // the rising edge. bc < 0 skips the beat counter check.
  task automatic cyc(input string name, input logic r, input logic [3:0] v,
                     input logic [3:0] l, input logic f, input logic [31:0] d,
                     input logic gv, input logic [1:0] gid, input logic wen,
                     input logic [7:0] wd, input logic [3:0] rdy, input int bc);
    rst = r; req_valid = v; req_last = l; fifo_full = f; req_data = d;
    @(negedge clk);
    chk({name, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    chk({name, ".grant_id"}, 32'(grant_id), 32'(gid));
    chk({name, ".fifo_wr_en"}, 32'(fifo_wr_en), 32'(wen));
    chk({name, ".req_ready"}, 32'(req_ready), 32'(rdy));
    if (gv || r || prev_rst) chk({name, ".fifo_wr_data"}, 32'(fifo_wr_data), 32'(wd));
    if (bc >= 0) chk({name, ".beat_cnt"}, 32'(dbg_beat_cnt), 32'(bc));
    if (wen) exp_q.push_back(wd);
    prev_rst = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       gv;
    logic [1:0] gid;
    logic       wen;
    logic [7:0] wdata;
    logic [3:0] ready;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic gv,
                              input logic [1:0] gid, input logic wen,
                              input logic [7:0] wd, input logic [3:0] rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.last = 4'b1111; t.full = 1'b0;
    t.gv = gv; t.gid = gid; t.wen = wen; t.wdata = wd; t.ready = rdy;
    return t;
  endfunction

  // ---------------- behavioural reference for random traffic ----------------
  int m_owner;   // -1 when nobody holds the port
  int m_ptr;     // last winner
  int m_beats;   // beats written in the current grant

  logic [3:0] rv, rl, acc;
  logic [7:0] rd[4];

  task automatic run_random(input int cycles);
    logic       e_gv, e_wen, full, r;
    logic [1:0] e_gid, own;
    logic [7:0] e_wd, got;
    logic [3:0] e_rdy;
    bit         found;
    int         cand;
    m_owner = -1; m_ptr = N - 1; m_beats = 0;
    rv = '0; rl = '0; acc = '0;
    for (int i = 0; i < N; i++) rd[i] = '0;
    for (int c = 0; c < cycles; c++) begin
      // fifo read side drains at random
      if (fifo_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        got = fifo_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rand.fifo_read: got 0x%0h expected no entry", got);
        end else begin
          chk("rand.fifo_read", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      // requesters hold a pending beat, otherwise pick something new
      for (int i = 0; i < N; i++) begin
        if (rv[i] && !acc[i]) begin
          if ($urandom_range(15, 0) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = ($urandom_range(2, 0) != 0);
          rl[i] = ($urandom_range(2, 0) == 0);
          rd[i] = 8'($urandom_range(255, 0));
        end
      end
      r    = ($urandom_range(199, 0) == 0);
      full = (fifo_q.size() >= DEPTH) || ($urandom_range(7, 0) == 0);
      // expected outputs from the reference state
      own   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      e_gv  = !r && (m_owner >= 0);
      e_gid = e_gv ? own : 2'd0;
      e_wen = e_gv && rv[own] && !full;
      e_wd  = e_gv ? rd[own] : 8'd0;
      e_rdy = (e_gv && !full) ? (4'd1 << own) : 4'd0;
      cyc("rand", r, rv, rl, full, {rd[3], rd[2], rd[1], rd[0]},
          e_gv, e_gid, e_wen, e_wd, e_rdy, e_gv ? m_beats : -1);
      acc = e_rdy & rv;
      // advance the reference
      if (r) begin
        m_owner = -1; m_ptr = N - 1; m_beats = 0;
      end else if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          cand = (m_ptr + k) % N;
          if (!found && rv[cand]) begin
            found = 1'b1; m_owner = cand; m_ptr = cand; m_beats = 0;
          end
        end
      end else if (e_wen) begin
        m_beats++;
        if (rl[own] || m_beats == MB) m_owner = -1;
      end else if (!rv[own]) begin
        m_owner = -1;
      end
    end
    rst = 1'b0; req_valid = '0; fifo_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc("reset0", 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 0);
    cyc("reset1", 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    // Table: reset, first arbitration (0 then 2), then fairness 0,1,2,3,0,1.
    vecs[0]  = mk(1'b1, 4'b0101, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[1]  = mk(1'b1, 4'b0101, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[2]  = mk(1'b0, 4'b0101, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[3]  = mk(1'b0, 4'b0101, 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
    vecs[4]  = mk(1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[5]  = mk(1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2, 4'b0100);
    vecs[6]  = mk(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[7]  = mk(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[8]  = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[9]  = mk(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
    vecs[10] = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[11] = mk(1'b0, 4'b1111, 1'b1, 2'd1, 1'b1, 8'hA1, 4'b0010);
    vecs[12] = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[13] = mk(1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 8'hA2, 4'b0100);
    vecs[14] = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[15] = mk(1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 8'hA3, 4'b1000);
    vecs[16] = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[17] = mk(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
    vecs[18] = mk(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
    vecs[19] = mk(1'b0, 4'b1111, 1'b1, 2'd1, 1'b1, 8'hA1, 4'b0010);
    vecs[20] = mk(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

    for (int i = 0; i < 21; i++) begin
      cyc($sformatf("table[%0d]", i), vecs[i].rst, vecs[i].valid, vecs[i].last,
          vecs[i].full, 32'hA3A2A1A0, vecs[i].gv, vecs[i].gid, vecs[i].wen,
          vecs[i].wdata, vecs[i].ready, -1);
    end
    drain_check("table");

    // Burst limit: req1 sends 0,10,20,30 | bubble | 40.
    do_reset();
    cyc("burst.c0", 0, 4'b0010, 4'b0000, 0, {16'h0, 8'd0, 8'h0},  0, 2'd0, 0, 8'd0,  4'b0000, -1);
    cyc("burst.c1", 0, 4'b0010, 4'b0000, 0, {16'h0, 8'd0, 8'h0},  1, 2'd1, 1, 8'd0,  4'b0010, 0);
    cyc("burst.c2", 0, 4'b0010, 4'b0000, 0, {16'h0, 8'd10, 8'h0}, 1, 2'd1, 1, 8'd10, 4'b0010, 1);
    cyc("burst.c3", 0, 4'b0010, 4'b0000, 0, {16'h0, 8'd20, 8'h0}, 1, 2'd1, 1, 8'd20, 4'b0010, 2);
    cyc("burst.c4", 0, 4'b0010, 4'b0000, 0, {16'h0, 8'd30, 8'h0}, 1, 2'd1, 1, 8'd30, 4'b0010, 3);
    cyc("burst.c5", 0, 4'b0010, 4'b0010, 0, {16'h0, 8'd40, 8'h0}, 0, 2'd0, 0, 8'd0,  4'b0000, -1);
    cyc("burst.c6", 0, 4'b0010, 4'b0010, 0, {16'h0, 8'd40, 8'h0}, 1, 2'd1, 1, 8'd40, 4'b0010, 0);
    cyc("burst.c7", 0, 4'b0000, 4'b0000, 0, 32'h0,                0, 2'd0, 0, 8'd0,  4'b0000, -1);
    drain_check("burst");

    // Backpressure: fifo_full for 3 cycles after two beats of req2.
    do_reset();
    cyc("bp.c0", 0, 4'b0100, 4'b0000, 0, {8'h0, 8'd5, 16'h0}, 0, 2'd0, 0, 8'd0, 4'b0000, -1);
    cyc("bp.c1", 0, 4'b0100, 4'b0000, 0, {8'h0, 8'd5, 16'h0}, 1, 2'd2, 1, 8'd5, 4'b0100, 0);
    cyc("bp.c2", 0, 4'b0100, 4'b0000, 0, {8'h0, 8'd6, 16'h0}, 1, 2'd2, 1, 8'd6, 4'b0100, 1);
    cyc("bp.c3", 0, 4'b0100, 4'b0000, 1, {8'h0, 8'd7, 16'h0}, 1, 2'd2, 0, 8'd7, 4'b0000, 2);
    cyc("bp.c4", 0, 4'b0100, 4'b0000, 1, {8'h0, 8'd7, 16'h0}, 1, 2'd2, 0, 8'd7, 4'b0000, 2);
    cyc("bp.c5", 0, 4'b0100, 4'b0000, 1, {8'h0, 8'd7, 16'h0}, 1, 2'd2, 0, 8'd7, 4'b0000, 2);
    cyc("bp.c6", 0, 4'b0100, 4'b0000, 0, {8'h0, 8'd7, 16'h0}, 1, 2'd2, 1, 8'd7, 4'b0100, 2);
    cyc("bp.c7", 0, 4'b0100, 4'b0100, 0, {8'h0, 8'd8, 16'h0}, 1, 2'd2, 1, 8'd8, 4'b0100, 3);
    cyc("bp.c8", 0, 4'b0000, 4'b0000, 0, 32'h0,               0, 2'd0, 0, 8'd0, 4'b0000, -1);
    drain_check("backpressure");

    // Withdrawal: req0 drops valid after 2 beats, then req2 and req3 follow.
    do_reset();
    cyc("wd.c0", 0, 4'b1101, 4'b1100, 0, 32'h33220011, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("wd.c1", 0, 4'b1101, 4'b1100, 0, 32'h33220011, 1, 2'd0, 1, 8'h11, 4'b0001, 0);
    cyc("wd.c2", 0, 4'b1101, 4'b1100, 0, 32'h33220012, 1, 2'd0, 1, 8'h12, 4'b0001, 1);
    cyc("wd.c3", 0, 4'b1100, 4'b1100, 0, 32'h33220012, 1, 2'd0, 0, 8'h12, 4'b0001, 2);
    cyc("wd.c4", 0, 4'b1100, 4'b1100, 0, 32'h33220012, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("wd.c5", 0, 4'b1100, 4'b1100, 0, 32'h33220012, 1, 2'd2, 1, 8'h22, 4'b0100, 0);
    cyc("wd.c6", 0, 4'b1000, 4'b1100, 0, 32'h33220012, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("wd.c7", 0, 4'b1000, 4'b1100, 0, 32'h33220012, 1, 2'd3, 1, 8'h33, 4'b1000, 0);
    cyc("wd.c8", 0, 4'b0000, 4'b0000, 0, 32'h0,        0, 2'd0, 0, 8'h00, 4'b0000, -1);
    drain_check("withdraw");

    // Reset mid-burst: req2's second beat is dropped; req0 wins over req3 after.
    do_reset();
    cyc("mrst.c0", 0, 4'b0100, 4'b0000, 0, 32'h00610000, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("mrst.c1", 0, 4'b0100, 4'b0000, 0, 32'h00610000, 1, 2'd2, 1, 8'h61, 4'b0100, 0);
    cyc("mrst.c2", 1, 4'b1101, 4'b1101, 0, 32'h73620070, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("mrst.c3", 0, 4'b1101, 4'b1101, 0, 32'h73620070, 0, 2'd0, 0, 8'h00, 4'b0000, 0);
    cyc("mrst.c4", 0, 4'b1101, 4'b1101, 0, 32'h73620070, 1, 2'd0, 1, 8'h70, 4'b0001, 0);
    cyc("mrst.c5", 0, 4'b1100, 4'b1100, 0, 32'h73620070, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("mrst.c6", 0, 4'b1100, 4'b1100, 0, 32'h73620070, 1, 2'd2, 1, 8'h62, 4'b0100, 0);
    cyc("mrst.c7", 0, 4'b1000, 4'b1000, 0, 32'h73620070, 0, 2'd0, 0, 8'h00, 4'b0000, -1);
    cyc("mrst.c8", 0, 4'b1000, 4'b1000, 0, 32'h73620070, 1, 2'd3, 1, 8'h73, 4'b1000, 0);
    cyc("mrst.c9", 0, 4'b0000, 4'b0000, 0, 32'h0,        0, 2'd0, 0, 8'h00, 4'b0000, -1);
    drain_check("mid_reset");

    // Random traffic against the reference model.
    do_reset();
    run_random(3000);
    drain_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
